// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_mux_arbiter : 4-way round-robin arbiter feeding one registered output slot
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    in_valid,
  input  logic [DW-1:0] in_data0,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  input  logic [DW-1:0] in_data3,
  output logic [3:0]    in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  input  logic          out_ready
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    last_q;
  logic [DW-1:0] data_q;
  logic [1:0]    sel_q;

  logic          slot_free;
  logic          grant_valid;
  logic [1:0]    grant;
  logic [1:0]    idx;
  logic          transfer;
  logic [DW-1:0] sel_data;

  // A full slot can be refilled in the same cycle it drains.
  assign slot_free = (state_q == EMPTY) || out_ready;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 2'd0;
    idx         = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (!grant_valid && in_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && slot_free && grant_valid) begin
      in_ready = 4'b0001 << grant;
    end
  end

  assign transfer = |in_ready;

  always_comb begin
    sel_data = in_data0;
    case (grant)
      2'd0: sel_data = in_data0;
      2'd1: sel_data = in_data1;
      2'd2: sel_data = in_data2;
      2'd3: sel_data = in_data3;
      default: sel_data = in_data0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (slot_free) begin
      state_d = transfer ? FULL : EMPTY;
    end
  end

  // Data, select and priority pointer move only on an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        data_q <= sel_data;
        sel_q  <= grant;
        last_q <= grant;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// Testbench for rr_mux_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a behavioural round-robin model.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] d [4];
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // behavioural model state
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_sel   = 0;
  int          m_last  = 3;
  logic [3:0]  seen_rdy;

  rr_mux_arbiter #(.DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data0 (d[0]),
    .in_data1 (d[1]),
    .in_data2 (d[2]),
    .in_data3 (d[3]),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check in_ready, advance model at edge, check outputs.
  task automatic step(input logic r, input logic [3:0] v, input logic ordy);
    int         g;
    bit         free;
    logic [3:0] exp_rdy;
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    #2;
    free    = !m_valid || ordy;
    g       = model_grant(v, m_last);
    exp_rdy = (!r && free && g >= 0) ? (4'b0001 << g) : 4'b0000;
    seen_rdy = in_ready;
    chk("model_in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_last  = 3;
    end else if (free) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = d[g];
        m_sel   = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("model_out_data", out_data, m_data);
    chk("model_out_sel", {30'd0, out_sel}, 32'(m_sel));
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 32'h10 + 32'(i);

    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 32'h00, 2'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h12, 2'd2};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'h13, 2'd3};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h10, 2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h10, 2'd0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h11, 2'd1};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'h10, 2'd0};
    tbl[11] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 32'h13, 2'd3};
    tbl[12] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 32'h00, 2'd0};
    tbl[13] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), {28'd0, seen_rdy}, {28'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_od);
      chk($sformatf("tbl%0d_out_sel", i), {30'd0, out_sel}, {30'd0, tbl[i].exp_sel});
    end

    // single requester
    step(1'b1, 4'b0000, 1'b1);
    d[2] = 32'hDEADBEEF;
    step(1'b0, 4'b0100, 1'b1);
    chk("single_in_ready", {28'd0, seen_rdy}, 32'h4);
    chk("single_out_valid", {31'd0, out_valid}, 32'h1);
    chk("single_out_data", out_data, 32'hDEADBEEF);
    chk("single_out_sel", {30'd0, out_sel}, 32'd2);

    // backpressure holds the word, then the next grant follows it
    step(1'b1, 4'b0000, 1'b0);
    d[0] = 32'hA5;
    step(1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b0);
      chk("bp_in_ready", {28'd0, seen_rdy}, 32'h0);
      chk("bp_out_data", out_data, 32'hA5);
      chk("bp_out_sel", {30'd0, out_sel}, 32'd0);
    end
    step(1'b0, 4'b1111, 1'b1);
    chk("bp_release_grant", {28'd0, seen_rdy}, 32'h2);

    // reset while full discards the word
    d[0] = 32'h1234;
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    chk("rstmid_full_data", out_data, 32'h1234);
    step(1'b1, 4'b1111, 1'b0);
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'h0);
    chk("rstmid_out_data", out_data, 32'h0);
    chk("rstmid_out_sel", {30'd0, out_sel}, 32'h0);
    step(1'b0, 4'b1111, 1'b1);
    chk("rstmid_first_grant", {28'd0, seen_rdy}, 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      step(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
